s1488_resp_capture: RTL and testbench
=====================================

Name: s1488_resp_capture

Overview:
- Downstream stage of the s1488 controller.
- Samples the controller's 19 decoded response outputs (v13_D_6..v13_D_24) every enabled cycle and detects when the vector changes.
- Each change is pushed as a timestamped record into a small first-word-fall-through FIFO.
- Records are drained by a host/monitor over a valid/ready interface; overflow is counted and flagged.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TSW, 16, timestamp counter width in bits.
- DCW, 8, drop-counter width in bits; the counter saturates.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- in_en  input  1  sample qualifier; in_vec is ignored when low.
- in_vec  input  19  controller outputs; bit0=v13_D_6, bit1=v13_D_7 ... bit18=v13_D_24.
- ovf_clr  input  1  single-cycle pulse; clears ovf and drop_cnt.
- rd_ready  input  1  consumer accepts the head record.
- rd_valid  output  1  a head record is available.
- rd_vec  output  19  head record vector.
- rd_stamp  output  TSW  head record timestamp.
- rd_ones  output  5  popcount of rd_vec.
- fifo_count  output  log2(DEPTH)+1  number of occupied entries.
- ovf  output  1  sticky; a record was dropped.
- drop_cnt  output  DCW  number of dropped records, saturating.

Behaviour:
- Reset (CLR high, asynchronous):
  - FIFO empties; rd_ptr, wr_ptr and fifo_count = 0.
  - rd_valid = 0; rd_vec, rd_stamp and rd_ones read as 0.
  - prev_vec = 0, timestamp = 0, ovf = 0, drop_cnt = 0.
  - Any record in flight or stored is discarded.
- Timestamp:
  - Free-running counter; +1 every CK edge while not in reset.
  - Wraps from all-ones to 0 with no flag.
  - A record's stamp is the counter value in the sampling cycle, before that edge's increment.
- Change detect:
  - chg = in_en & (in_vec != prev_vec).
  - On every edge with in_en=1, prev_vec <= in_vec.
  - in_en=0 holds prev_vec and never creates a record.
  - Because prev_vec resets to 0, the first nonzero enabled sample after reset always produces a record.
- Push: on an edge where chg=1, write {in_vec, stamp} at wr_ptr if a slot is available.
- Slot available means fifo_count < DEPTH, or (fifo_count == DEPTH and pop occurs in the same cycle).
- Pop: on an edge where rd_valid & rd_ready, advance rd_ptr. When rd_valid=0, rd_ready is ignored.
- Count update:
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Push only: +1. Pop only: -1.
- Pointers wrap modulo DEPTH; the extra MSB distinguishes full from empty.
- FWFT read side:
  - rd_valid = (fifo_count != 0).
  - rd_vec and rd_stamp show the head entry combinationally from the storage array.
  - Latency: a change sampled at edge N into an empty FIFO gives rd_valid=1 after edge N (visible in cycle N+1).
  - A record pushed into an empty FIFO is never popped in the same cycle.
- rd_ones = number of set bits in rd_vec, range 0..19; 0 when rd_valid=0.
- Drop: chg=1 with no slot available means:
  - the record is discarded;
  - ovf <= 1;
  - drop_cnt increments, saturating at all-ones;
  - prev_vec still updates, so the next record reflects the next change, not a replay.
- Overflow clear:
  - ovf_clr on an edge clears ovf and drop_cnt.
  - If a drop happens on the same edge, the drop wins: ovf=1, drop_cnt=1.
- The head entry stays stable while rd_valid=1 and rd_ready=0, including while pushes continue behind it.

Test Plan (DEPTH=4, TSW=8, DCW=8):
- Reset, then in_en=1, in_vec=0x00001 at stamp 3 -> next cycle: rd_valid=1, rd_vec=0x00001, rd_stamp=3, rd_ones=1, fifo_count=1.
- Hold in_vec constant for 10 cycles with in_en=1, then toggle in_en=0 while changing in_vec -> no new records; fifo_count stays 1.
- rd_ready=0; apply 6 distinct changes on consecutive cycles -> fifo_count=4, ovf=1, drop_cnt=2; pop all -> four records with the first four vectors in order and stamps 0,1,2,3 relative to the first change.
- FIFO full plus a change plus rd_ready=1 in the same cycle -> no drop; fifo_count stays 4; new tail = new vector.
- Run 300 cycles, then change in_vec=0x7FFFF -> rd_stamp=(300+offset) mod 256; rd_ones=19.
- ovf_clr and a drop on the same edge -> ovf=1, drop_cnt=1. Assert CLR asynchronously mid-drain with 3 entries -> rd_valid=0 immediately; fifo_count=0; the next nonzero sample is recorded.

Source files
------------

// File: rtl/s1488_resp_capture.sv
// rtl/s1488_resp_capture.sv - s1488 response change capture into a timestamped FWFT FIFO
module s1488_resp_capture #(
    parameter int DEPTH = 8,
    parameter int TSW   = 16,
    parameter int DCW   = 8
) (
    input  logic                       CK,
    input  logic                       CLR,
    input  logic                       in_en,
    input  logic [18:0]                in_vec,
    input  logic                       ovf_clr,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [18:0]                rd_vec,
    output logic [TSW-1:0]             rd_stamp,
    output logic [4:0]                 rd_ones,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       ovf,
    output logic [DCW-1:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [18:0]    r_mem_vec   [DEPTH];
    logic [TSW-1:0] r_mem_stamp [DEPTH];
    logic [AW:0]    r_rd_ptr;
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_count;
    logic [18:0]    r_prev_vec;
    logic [TSW-1:0] r_stamp;
    logic           r_ovf;
    logic [DCW-1:0] r_drop_cnt;

    logic           w_chg;
    logic           w_pop;
    logic           w_slot;
    logic           w_push;
    logic           w_drop;
    logic [4:0]     w_ones;

    assign w_chg  = in_en & (in_vec != r_prev_vec);
    assign w_pop  = rd_valid & rd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_slot = (r_count < FULL_CNT) | w_pop;
    assign w_push = w_chg & w_slot;
    assign w_drop = w_chg & ~w_slot;

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_prev_vec <= '0;
            r_stamp    <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_stamp <= r_stamp + TSW'(1);
            if (in_en) begin
                r_prev_vec <= in_vec;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            // A drop on the same edge as a clear restarts the tally at one.
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (ovf_clr) begin
                    r_drop_cnt <= DCW'(1);
                end else if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DCW'(1);
                end
            end else if (ovf_clr) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (w_push) begin
            r_mem_vec[r_wr_ptr[AW-1:0]]   <= in_vec;
            r_mem_stamp[r_wr_ptr[AW-1:0]] <= r_stamp;
        end
    end

    assign rd_valid   = (r_count != '0);
    assign rd_vec     = rd_valid ? r_mem_vec[r_rd_ptr[AW-1:0]] : '0;
    assign rd_stamp   = rd_valid ? r_mem_stamp[r_rd_ptr[AW-1:0]] : '0;
    assign fifo_count = r_count;
    assign ovf        = r_ovf;
    assign drop_cnt   = r_drop_cnt;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 19; i++) begin
            w_ones = w_ones + 5'(rd_vec[i]);
        end
    end

    assign rd_ones = w_ones;
endmodule

// File: tb/tb_s1488_resp_capture.sv
// tb/tb_s1488_resp_capture.sv - directed self-checking bench for s1488_resp_capture
module tb_s1488_resp_capture;
    logic        CK = 1'b0;
    logic        CLR = 1'b1;
    logic        in_en = 1'b0;
    logic [18:0] in_vec = '0;
    logic        ovf_clr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [18:0] rd_vec;
    logic [7:0]  rd_stamp;
    logic [4:0]  rd_ones;
    logic [2:0]  fifo_count;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int tb_stamp = 0;

    s1488_resp_capture #(.DEPTH(4), .TSW(8), .DCW(8)) dut (
        .CK(CK), .CLR(CLR), .in_en(in_en), .in_vec(in_vec), .ovf_clr(ovf_clr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_vec(rd_vec), .rd_stamp(rd_stamp),
        .rd_ones(rd_ones), .fifo_count(fifo_count), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 CK = ~CK;

    task automatic tick;
        @(posedge CK);
        #1;
        tb_stamp = tb_stamp + 1;
    endtask

    task automatic test_reset;
        #3;
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d want 0", rd_valid); end
        n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_chk++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf: got ovf=%0d drop=%0d want 0/0", ovf, drop_cnt); end
        n_chk++; if (rd_vec !== 19'd0 || rd_stamp !== 8'd0 || rd_ones !== 5'd0) begin n_fail++; $display("FAIL reset_head: got vec=%h stamp=%0d ones=%0d want 0", rd_vec, rd_stamp, rd_ones); end
        @(posedge CK);
        #1;
        CLR = 1'b0;
        tb_stamp = 0;
        tick(); tick(); tick();
        in_en = 1'b1;
        in_vec = 19'h00001;
        tick();
        n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %0d want 1", rd_valid); end
        n_chk++; if (rd_vec !== 19'h00001) begin n_fail++; $display("FAIL first_vec: got %h want 00001", rd_vec); end
        n_chk++; if (rd_stamp !== 8'd3) begin n_fail++; $display("FAIL first_stamp: got %0d want 3", rd_stamp); end
        n_chk++; if (rd_ones !== 5'd1) begin n_fail++; $display("FAIL first_ones: got %0d want 1", rd_ones); end
        n_chk++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", fifo_count); end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 10; i++) tick();
        n_chk++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL hold_count: got %0d want 1", fifo_count); end
        in_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vec = 19'h00010 << i;
            tick();
        end
        n_chk++; if (fifo_count !== 3'd1 || rd_vec !== 19'h00001) begin n_fail++; $display("FAIL disabled_count: got cnt=%0d vec=%h want 1/00001", fifo_count, rd_vec); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_chk++; if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_one: got cnt=%0d valid=%0d want 0/0", fifo_count, rd_valid); end
    endtask

    task automatic test_overflow;
        logic [18:0] v [6];
        int s0;
        v = '{19'h00002, 19'h00004, 19'h00008, 19'h00010, 19'h00020, 19'h00040};
        in_en = 1'b1;
        s0 = tb_stamp;
        for (int i = 0; i < 6; i++) begin
            in_vec = v[i];
            tick();
        end
        in_en = 1'b0;
        n_chk++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        n_chk++; if (ovf !== 1'b1 || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_flag: got ovf=%0d drop=%0d want 1/2", ovf, drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (rd_vec !== v[i] || rd_stamp !== 8'(s0 + i)) begin n_fail++; $display("FAIL ovf_pop%0d: got vec=%h stamp=%0d want %h/%0d", i, rd_vec, rd_stamp, v[i], 8'(s0 + i)); end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_full_push_pop;
        logic [18:0] v [5];
        v = '{19'h00100, 19'h00200, 19'h00400, 19'h00800, 19'h01000};
        in_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_vec = v[i];
            tick();
        end
        n_chk++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        in_vec = v[4];
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        in_en = 1'b0;
        n_chk++; if (fifo_count !== 3'd4 || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL full_pushpop: got cnt=%0d drop=%0d want 4/2", fifo_count, drop_cnt); end
        for (int i = 1; i < 5; i++) begin
            n_chk++; if (rd_vec !== v[i]) begin n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, rd_vec, v[i]); end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
    endtask

    task automatic test_stamp_wrap;
        int s;
        in_en = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_vec = 19'h7FFFF;
        s = tb_stamp;
        tick();
        n_chk++; if (rd_stamp !== 8'(s)) begin n_fail++; $display("FAIL wrap_stamp: got %0d want %0d", rd_stamp, 8'(s)); end
        n_chk++; if (rd_ones !== 5'd19 || rd_vec !== 19'h7FFFF) begin n_fail++; $display("FAIL wrap_ones: got ones=%0d vec=%h want 19/7ffff", rd_ones, rd_vec); end
        rd_ready = 1'b1;
        in_en = 1'b0;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_ovf_clr;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_chk++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clear: got ovf=%0d drop=%0d want 0/0", ovf, drop_cnt); end
        in_en = 1'b1;
        in_vec = 19'h00001; tick();
        in_vec = 19'h00003; tick();
        in_vec = 19'h00007; tick();
        in_vec = 19'h0000F; tick();
        in_vec = 19'h0001F;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        in_en = 1'b0;
        n_chk++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_vs_drop: got ovf=%0d drop=%0d want 1/1", ovf, drop_cnt); end
    endtask

    task automatic test_async_reset;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_chk++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 3", fifo_count); end
        #2;
        CLR = 1'b1;
        #1;
        n_chk++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL async_clr: got valid=%0d cnt=%0d ovf=%0d want 0/0/0", rd_valid, fifo_count, ovf); end
        @(posedge CK);
        #1;
        CLR = 1'b0;
        tb_stamp = 0;
        in_en = 1'b1;
        in_vec = 19'h00005;
        tick();
        n_chk++; if (rd_valid !== 1'b1 || rd_vec !== 19'h00005 || rd_stamp !== 8'd0 || rd_ones !== 5'd2) begin n_fail++; $display("FAIL post_reset: got valid=%0d vec=%h stamp=%0d ones=%0d want 1/00005/0/2", rd_valid, rd_vec, rd_stamp, rd_ones); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_overflow();
        test_full_push_pop();
        test_stamp_wrap();
        test_ovf_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
